// File: rtl/uart_tx_if.sv
// Host-side handshake bundle for uart_tx.
//   write    : host write strobe
//   data     : byte to enqueue
//   full     : FIFO full, writes ignored
//   overflow : one-cycle pulse after a write that was dropped
//   busy     : frame on the line or bytes still queued
interface uart_tx_if;
  logic       write;
  logic [7:0] data;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (output write, data, input full, overflow, busy);
  modport slave  (input write, data, output full, overflow, busy);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a small byte FIFO.
// Ports:
//   dclk    : transmit clock, rising edge
//   rst     : asynchronous active-low reset
//   host    : uart_tx_if.slave (write/data in, full/overflow/busy out)
//   divisor : bit period in dclk cycles, 0 behaves as 1; sampled per frame
//   tx      : serial line, idle high, driven from a flop
//
// state   | meaning
// IDLE    | line idle high, waiting for a queued byte
// START   | start bit (0) for one period
// DATA    | data bits LSB first, one period each
// STOP    | stop bit (1); chains straight into START if more bytes wait
module uart_tx #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic          dclk,
  input  logic          rst,
  uart_tx_if.slave      host,
  input  logic [DW-1:0] divisor,
  output logic          tx
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full_q;
  logic          ovf_q;

  logic [1:0]    state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [DW-1:0] baud_cnt;
  logic [DW-1:0] period;
  logic          tx_q;

  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          baud_done;
  logic [DW-1:0] div_eff;

  assign fifo_empty = (count == '0);
  assign push       = host.write & ~full_q;
  assign baud_done  = (baud_cnt == period - DW'(1));
  // Pop either from idle or on the last stop-bit cycle, so queued frames
  // follow each other with no idle gap.
  assign pop        = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & baud_done));
  assign div_eff    = (divisor == '0) ? DW'(1) : divisor;

  always_ff @(posedge dclk) begin
    if (push) mem[wr_ptr] <= host.data;
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= host.write & full_q;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10: begin
          count  <= count + CW'(1);
          full_q <= ((count + CW'(1)) == DEPTH_C);
        end
        2'b01: begin
          count  <= count - CW'(1);
          full_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      period   <= '0;
      tx_q     <= 1'b1;
    end else begin
      if (state != S_IDLE) begin
        baud_cnt <= baud_done ? '0 : baud_cnt + DW'(1);
      end
      case (state)
        S_START: begin
          if (baud_done) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx_q    <= shift[0];
          end
        end
        S_DATA: begin
          if (baud_done) begin
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx_q  <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[1];
            end
          end
        end
        S_STOP: begin
          if (baud_done && fifo_empty) begin
            state <= S_IDLE;
            tx_q  <= 1'b1;
          end
        end
        default: ;
      endcase
      // A pop (from IDLE or end of STOP) always starts a fresh frame and
      // takes precedence over the per-state updates above.
      if (pop) begin
        state    <= S_START;
        shift    <= mem[rd_ptr];
        period   <= div_eff;
        baud_cnt <= '0;
        tx_q     <= 1'b0;
      end
    end
  end

  assign tx            = tx_q;
  assign host.full     = full_q;
  assign host.overflow = ovf_q;
  assign host.busy     = (state != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  typedef struct {
    logic [7:0] b;
    int         per;
  } exp_t;

  logic        dclk = 1'b0;
  logic        rst;
  logic [15:0] divisor;
  logic        tx;

  uart_tx_if hif ();

  uart_tx #(.DEPTH(4), .DW(16)) dut (
    .dclk    (dclk),
    .rst     (rst),
    .host    (hif),
    .divisor (divisor),
    .tx      (tx)
  );

  always #5 dclk = ~dclk;

  int         n_checks = 0;
  int         n_err    = 0;
  exp_t       sb[$];

  logic       mon_on = 1'b0;
  int         mon_k;
  int         glitch;
  int         bi;
  exp_t       cur;
  logic [9:0] obs;
  logic [9:0] exp_fr;
  logic [9:0] cap;
  int         bad;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic put(input logic [7:0] b, input bit accept, input int per);
    hif.write = 1'b1;
    hif.data  = b;
    if (accept) sb.push_back('{b: b, per: per});
    @(negedge dclk);
    hif.write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (hif.busy !== 1'b0 && i < budget) begin
      @(negedge dclk);
      i++;
    end
    chk("idle_within_budget", {31'd0, hif.busy}, 32'd0);
    repeat (2) @(negedge dclk);
  endtask

  task automatic capture10();
    for (int i = 0; i < 10; i++) begin
      @(negedge dclk);
      cap[i] = tx;
    end
  endtask

  initial begin
    rst       = 1'b0;
    hif.write = 1'b0;
    hif.data  = 8'h00;
    divisor   = 16'd1;

    fork
      // Line decoder: checks every sample of each frame against the
      // scoreboard byte and its expected bit period.
      forever begin
        @(negedge dclk);
        if (rst !== 1'b1) begin
          mon_on = 1'b0;
        end else begin
          if (!mon_on && tx === 1'b0) begin
            n_checks++;
            assert (sb.size() > 0) else begin
              n_err++;
              $error("FAIL unexpected_frame observed=start_bit expected=idle_line");
            end
            if (sb.size() > 0) begin
              cur    = sb.pop_front();
              mon_on = 1'b1;
              mon_k  = 0;
              glitch = 0;
              obs    = '0;
              exp_fr = {1'b1, cur.b, 1'b0};
            end
          end
          if (mon_on) begin
            bi = mon_k / cur.per;
            if (tx !== exp_fr[bi]) glitch++;
            if ((mon_k % cur.per) == cur.per - 1) obs[bi] = tx;
            mon_k++;
            if (mon_k == 10 * cur.per) begin
              chk("frame_bits", {22'd0, obs}, {22'd0, exp_fr});
              chk("frame_timing", glitch, 0);
              mon_on = 1'b0;
            end
          end
        end
      end

      begin
        repeat (20000) @(negedge dclk);
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
      end

      begin
        // Reset state
        repeat (2) @(negedge dclk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_full", {31'd0, hif.full}, 32'd0);
        chk("rst_overflow", {31'd0, hif.overflow}, 32'd0);
        chk("rst_busy", {31'd0, hif.busy}, 32'd0);
        #1 rst = 1'b1;
        @(negedge dclk);

        // Single byte 0x41, divisor 1: exact waveform and busy fall at N+11
        put(8'h41, 1'b1, 1);
        capture10();
        chk("wave_41", {22'd0, cap}, {22'd0, 10'b10_1000_0010});
        chk("busy_n10", {31'd0, hif.busy}, 32'd1);
        @(negedge dclk);
        chk("busy_n11", {31'd0, hif.busy}, 32'd0);
        repeat (2) @(negedge dclk);

        // Back-to-back 'H','i': no gap means busy falls exactly at N+21
        put(8'h48, 1'b1, 1);
        put(8'h69, 1'b1, 1);
        repeat (19) @(negedge dclk);
        chk("hi_busy_n20", {31'd0, hif.busy}, 32'd1);
        @(negedge dclk);
        chk("hi_busy_n21", {31'd0, hif.busy}, 32'd0);
        repeat (2) @(negedge dclk);

        // divisor 3, byte 0x00
        divisor = 16'd3;
        put(8'h00, 1'b1, 3);
        wait_idle(100);

        // divisor 0 behaves as 1
        divisor = 16'd0;
        put(8'h41, 1'b1, 1);
        capture10();
        chk("wave_div0", {22'd0, cap}, {22'd0, 10'b10_1000_0010});
        @(negedge dclk);
        chk("div0_busy_n11", {31'd0, hif.busy}, 32'd0);
        repeat (2) @(negedge dclk);

        // Six consecutive writes into DEPTH=4
        divisor = 16'd1;
        for (int i = 0; i < 6; i++) begin
          hif.write = 1'b1;
          hif.data  = 8'h10 + 8'(i);
          if (i < 5) sb.push_back('{b: 8'h10 + 8'(i), per: 1});
          @(negedge dclk);
          chk($sformatf("fill_full_%0d", i), {31'd0, hif.full}, {31'd0, (i >= 4)});
          chk($sformatf("fill_ovf_%0d", i), {31'd0, hif.overflow}, {31'd0, (i == 5)});
          if (i == 0) chk("fill_tx_idle", {31'd0, tx}, 32'd1);
          if (i == 1) chk("fill_tx_start", {31'd0, tx}, 32'd0);
        end
        hif.write = 1'b0;
        @(negedge dclk);
        chk("ovf_pulse_end", {31'd0, hif.overflow}, 32'd0);
        wait_idle(200);

        // Reset during DATA bit 4 of 0xA5 with two bytes queued
        put(8'hA5, 1'b1, 1);
        put(8'h11, 1'b1, 1);
        put(8'h22, 1'b1, 1);
        repeat (4) @(negedge dclk);
        chk("a5_bit4", {31'd0, tx}, 32'd0);
        chk("a5_busy", {31'd0, hif.busy}, 32'd1);
        #1 rst = 1'b0;
        sb.delete();
        #1;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_full", {31'd0, hif.full}, 32'd0);
        chk("abort_busy", {31'd0, hif.busy}, 32'd0);
        @(negedge dclk);
        #1 rst = 1'b1;
        bad = 0;
        repeat (30) begin
          @(negedge dclk);
          if (tx !== 1'b1 || hif.busy !== 1'b0) bad++;
        end
        chk("post_abort_quiet", bad, 0);

        // Divisor change mid-frame applies to the next frame only
        divisor = 16'd1;
        put(8'h3C, 1'b1, 1);
        put(8'hC3, 1'b1, 4);
        divisor = 16'd4;
        wait_idle(200);

        chk("sb_drained", sb.size(), 0);
        chk("monitor_idle", {31'd0, mon_on}, 32'd0);
      end
    join_any
    disable fork;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
